// File: rtl/mult8_seq_pkg.sv
// Shared types and step schedule for the sequential 8x8 multiplier built on a 4x4 core.
package mult8_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned N_STEPS = 4;

  // Element [s] belongs to step s: shifts {0,4,4,8}.
  localparam logic [N_STEPS-1:0][3:0] STEP_SHIFT = {4'd8, 4'd4, 4'd4, 4'd0};

  // Bit [s] set selects the high nibble of that operand on step s.
  localparam logic [N_STEPS-1:0] STEP_A_HI = 4'b1100;
  localparam logic [N_STEPS-1:0] STEP_B_HI = 4'b1010;

endpackage

// File: rtl/mult8_seq_accum_mult4.sv
// Combinational 4x4 unsigned multiplier core (shift-and-add array).
module mult4_array (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [7:0] P
);

  always_comb begin
    P = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (B[i]) P = P + ({4'b0, A} << i);
    end
  end

endmodule

// File: rtl/mult8_seq_accum.sv
// Sequential 8x8 unsigned multiplier: one 4x4 core reused over four steps,
// partial products accumulated into a 16-bit result behind valid/ready handshakes.
module mult8_seq_accum
  import mult8_seq_pkg::*;
#(
  parameter int unsigned EARLY_ZERO = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] p,
  output logic        busy
);

  state_t      state;
  logic [1:0]  step;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [15:0] acc;
  logic [3:0]  core_a;
  logic [3:0]  core_b;
  logic [7:0]  core_p;
  logic [15:0] partial;
  logic        accept;
  logic        zero_skip;

  assign core_a  = STEP_A_HI[step] ? a_q[7:4] : a_q[3:0];
  assign core_b  = STEP_B_HI[step] ? b_q[7:4] : b_q[3:0];
  assign partial = {8'b0, core_p} << STEP_SHIFT[step];

  mult4_array u_core (
    .A (core_a),
    .B (core_b),
    .P (core_p)
  );

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_valid = (state == DONE);
  assign busy      = (state == MUL);
  assign p         = acc;
  assign accept    = in_valid && in_ready;
  assign zero_skip = (EARLY_ZERO != 0) && ((a == 8'd0) || (b == 8'd0));

  // Accept has priority so a new pair taken in the DONE cycle skips IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      step  <= '0;
      acc   <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      acc   <= '0;
      step  <= '0;
      state <= zero_skip ? DONE : MUL;
    end else begin
      case (state)
        MUL: begin
          acc  <= acc + partial;
          step <= step + 2'd1;
          if (step == 2'd3) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        IDLE: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
